// File: rtl/segre_icache_data_array.sv
// Set-associative icache data array: multi-beat line refill from the MMU and
// 1-cycle word reads; only reads that hit the line being filled are held off.
module segre_icache_data_array #(
  parameter int unsigned NUM_WAYS   = 2,
  parameter int unsigned NUM_SETS   = 16,
  parameter int unsigned LINE_BYTES = 16,
  parameter int unsigned WORD_SIZE  = 32,
  parameter int unsigned FILL_WIDTH = 32,
  localparam int unsigned BEATS     = LINE_BYTES * 8 / FILL_WIDTH,
  localparam int unsigned SW        = $clog2(NUM_SETS),
  localparam int unsigned WW        = (NUM_WAYS > 1) ? $clog2(NUM_WAYS) : 1,
  localparam int unsigned BW        = $clog2(LINE_BYTES),
  localparam int unsigned CW        = (BEATS > 1) ? $clog2(BEATS) : 1
) (
  input  logic                  clk_i,
  input  logic                  rsn_i,
  input  logic                  rd_req_i,
  input  logic [SW-1:0]         rd_set_i,
  input  logic [WW-1:0]         rd_way_i,
  input  logic [BW-1:0]         rd_byte_i,
  output logic                  rd_gnt_o,
  output logic                  rd_valid_o,
  output logic [WORD_SIZE-1:0]  rd_data_o,
  input  logic                  fill_start_i,
  input  logic [SW-1:0]         fill_set_i,
  input  logic [WW-1:0]         fill_way_i,
  input  logic                  fill_beat_valid_i,
  input  logic [FILL_WIDTH-1:0] fill_beat_data_i,
  output logic                  fill_beat_ready_o,
  output logic                  fill_busy_o,
  output logic                  fill_done_o
);

  localparam int unsigned WORDS = LINE_BYTES * 8 / WORD_SIZE;
  localparam int unsigned OB    = $clog2(WORD_SIZE / 8);
  localparam int unsigned WSW   = (WORDS > 1) ? $clog2(WORDS) : 1;
  localparam int unsigned IW    = SW + WW;
  localparam int unsigned DEPTH = 1 << IW;

  typedef enum logic [1:0] {IDLE, FILL, DONE} state_e;

  state_e          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [SW-1:0]   fset_q;
  logic [WW-1:0]   fway_q;
  logic            latch_en;
  logic            beat_we;

  logic [BEATS-1:0][FILL_WIDTH-1:0] mem [DEPTH];
  logic [WORDS-1:0][WORD_SIZE-1:0]  rd_line;
  logic [WSW-1:0]                   word_sel;
  logic [IW-1:0]                    rd_idx;
  logic [IW-1:0]                    wr_idx;

  // Refill state register
  always_ff @(posedge clk_i or negedge rsn_i) begin
    if (!rsn_i) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      fset_q  <= '0;
      fway_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      if (latch_en) begin
        fset_q <= fill_set_i;
        fway_q <= fill_way_i;
      end
    end
  end

  // Refill next-state, beat counter and handshake decode
  always_comb begin
    state_d           = state_q;
    cnt_d             = cnt_q;
    latch_en          = 1'b0;
    beat_we           = 1'b0;
    fill_beat_ready_o = 1'b0;
    fill_busy_o       = 1'b0;
    fill_done_o       = 1'b0;
    case (state_q)
      IDLE: begin
        if (fill_start_i) begin
          latch_en = 1'b1;
          cnt_d    = '0;
          state_d  = FILL;
        end
      end
      FILL: begin
        fill_busy_o       = 1'b1;
        fill_beat_ready_o = 1'b1;
        if (fill_beat_valid_i) begin
          beat_we = 1'b1;
          if (cnt_q == CW'(BEATS - 1)) begin
            cnt_d   = '0;
            state_d = DONE;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
      end
      DONE: begin
        fill_busy_o = 1'b1;
        fill_done_o = 1'b1;
        state_d     = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign wr_idx = {fway_q, fset_q};
  assign rd_idx = {rd_way_i, rd_set_i};

  // Reads are held off only for the line currently being filled
  assign rd_gnt_o = rsn_i && rd_req_i &&
                    !(state_q == FILL && rd_set_i == fset_q && rd_way_i == fway_q);

  // Line storage; reset clears every byte so a stale line never survives a reset
  always_ff @(posedge clk_i or negedge rsn_i) begin
    if (!rsn_i) begin
      for (int i = 0; i < int'(DEPTH); i++) mem[i] <= '0;
    end else if (beat_we) begin
      mem[wr_idx][cnt_q] <= fill_beat_data_i;
    end
  end

  assign rd_line  = mem[rd_idx];
  assign word_sel = WSW'(rd_byte_i >> OB);

  // Read data register; holds its value when no read is granted
  always_ff @(posedge clk_i or negedge rsn_i) begin
    if (!rsn_i) begin
      rd_valid_o <= 1'b0;
      rd_data_o  <= '0;
    end else begin
      rd_valid_o <= rd_gnt_o;
      if (rd_gnt_o) rd_data_o <= rd_line[word_sel];
    end
  end

endmodule

// File: tb/tb_segre_icache_data_array.sv
// Directed bench for segre_icache_data_array: reset, refills with and without
// gaps, read blocking/bypass during fills, ignored restarts and mid-fill reset.
module tb_segre_icache_data_array;

  logic        clk = 1'b0;
  logic        rsn;
  logic        rd_req;
  logic [3:0]  rd_set;
  logic [0:0]  rd_way;
  logic [3:0]  rd_byte;
  logic        rd_gnt;
  logic        rd_valid;
  logic [31:0] rd_data;
  logic        fill_start;
  logic [3:0]  fill_set;
  logic [0:0]  fill_way;
  logic        beat_valid;
  logic [31:0] beat_data;
  logic        beat_ready;
  logic        fill_busy;
  logic        fill_done;

  int n_vec = 0;
  int n_err = 0;

  segre_icache_data_array dut (
    .clk_i             (clk),
    .rsn_i             (rsn),
    .rd_req_i          (rd_req),
    .rd_set_i          (rd_set),
    .rd_way_i          (rd_way),
    .rd_byte_i         (rd_byte),
    .rd_gnt_o          (rd_gnt),
    .rd_valid_o        (rd_valid),
    .rd_data_o         (rd_data),
    .fill_start_i      (fill_start),
    .fill_set_i        (fill_set),
    .fill_way_i        (fill_way),
    .fill_beat_valid_i (beat_valid),
    .fill_beat_data_i  (beat_data),
    .fill_beat_ready_o (beat_ready),
    .fill_busy_o       (fill_busy),
    .fill_done_o       (fill_done)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_read(input logic [3:0] s, input logic w, input logic [3:0] b,
                         input logic [31:0] exp);
    rd_req = 1'b1; rd_set = s; rd_way = w; rd_byte = b;
    #1 chk("rd_gnt", 32'(rd_gnt), 32'd1);
    step();
    rd_req = 1'b0;
    chk("rd_valid", 32'(rd_valid), 32'd1);
    chk("rd_data", rd_data, exp);
    step();
    chk("rd_valid_drop", 32'(rd_valid), 32'd0);
    chk("rd_data_hold", rd_data, exp);
  endtask

  // rd_mode 0: no reads, 1: same line every fill cycle, 2: other lines every cycle
  task automatic drive_rd(input int mode, input int cyc, input logic [3:0] s, input logic w);
    rd_req = (mode != 0); rd_byte = 4'd0;
    if (mode == 1) begin
      rd_set = s; rd_way = w;
    end else if (cyc % 2 == 0) begin
      rd_set = s; rd_way = ~w;
    end else begin
      rd_set = s + 4'd1; rd_way = w;
    end
  endtask

  task automatic after_rd(input int mode);
    chk("fill_rd_valid", 32'(rd_valid), (mode == 2) ? 32'd1 : 32'd0);
    if (mode == 2) chk("fill_rd_other", rd_data, 32'h0);
    chk("done_early", 32'(fill_done), 32'd0);
  endtask

  task automatic do_fill(input logic [3:0] s, input logic w, input logic [31:0] base,
                         input int gap_len, input int mode, input logic intrude,
                         input logic [31:0] old0);
    int cyc;
    fill_start = 1'b1; fill_set = s; fill_way = w;
    rd_req = 1'b1; rd_set = s; rd_way = w; rd_byte = 4'd0;
    #1 chk("gnt_at_start", 32'(rd_gnt), 32'd1);
    step();
    cyc = 1;
    fill_start = 1'b0; rd_req = 1'b0;
    chk("rd_old_data", rd_data, old0);
    chk("busy", 32'(fill_busy), 32'd1);
    for (int k = 0; k < 4; k++) begin
      if (k == 2) begin
        for (int g = 0; g < gap_len; g++) begin
          beat_valid = 1'b0; beat_data = 32'hDEADBEEF;
          drive_rd(mode, cyc, s, w);
          #1 chk("gnt_gap", 32'(rd_gnt), (mode == 2) ? 32'd1 : 32'd0);
          step(); cyc++;
          after_rd(mode);
        end
      end
      beat_valid = 1'b1;
      beat_data  = base + 32'(k) * 32'h04040404;
      if (intrude && k == 1) begin
        fill_start = 1'b1; fill_set = 4'd2; fill_way = 1'b0;
      end
      drive_rd(mode, cyc, s, w);
      #1 chk("ready", 32'(beat_ready), 32'd1);
      chk("gnt_beat", 32'(rd_gnt), (mode == 2 || mode == 0) ? 32'(mode == 2) : 32'd0);
      step(); cyc++;
      fill_start = 1'b0;
      if (k < 3) after_rd(mode);
      else chk("fill_rd_valid_last", 32'(rd_valid), (mode == 2) ? 32'd1 : 32'd0);
    end
    beat_valid = 1'b0;
    chk("done", 32'(fill_done), 32'd1);
    chk("ready_in_done", 32'(beat_ready), 32'd0);
    rd_req = 1'b1; rd_set = s; rd_way = w; rd_byte = 4'd12;
    #1 chk("gnt_in_done", 32'(rd_gnt), 32'd1);
    step();
    rd_req = 1'b0;
    chk("rd_new_in_done", rd_data, base + 32'h0C0C0C0C);
    chk("done_pulse", 32'(fill_done), 32'd0);
    chk("busy_end", 32'(fill_busy), 32'd0);
  endtask

  initial begin
    rsn = 1'b0;
    rd_req = 1'b0; rd_set = '0; rd_way = '0; rd_byte = '0;
    fill_start = 1'b0; fill_set = '0; fill_way = '0;
    beat_valid = 1'b0; beat_data = '0;

    // Reset with toggling inputs: every output must stay 0
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); #1;
      rd_req = 1'($urandom); rd_set = 4'($urandom); rd_way = 1'($urandom);
      rd_byte = 4'($urandom); fill_start = 1'($urandom); fill_set = 4'($urandom);
      fill_way = 1'($urandom); beat_valid = 1'($urandom); beat_data = $urandom;
      #1;
      chk("rst_outs", {25'd0, rd_gnt, rd_valid, beat_ready, fill_busy, fill_done, 2'b00}, 32'd0);
      chk("rst_data", rd_data, 32'd0);
    end
    rd_req = 1'b0; fill_start = 1'b0; beat_valid = 1'b0;
    step();
    rsn = 1'b1;
    step();

    do_read(4'd3, 1'b1, 4'd4, 32'h0);

    // Gapless fill of set 5 way 0
    do_fill(4'd5, 1'b0, 32'h03020100, 0, 0, 1'b0, 32'h0);
    do_read(4'd5, 1'b0, 4'd0,  32'h03020100);
    do_read(4'd5, 1'b0, 4'd4,  32'h07060504);
    do_read(4'd5, 1'b0, 4'd8,  32'h0B0A0908);
    do_read(4'd5, 1'b0, 4'd12, 32'h0F0E0D0C);
    do_read(4'd5, 1'b0, 4'd6,  32'h07060504);

    // Refill with a 3-cycle gap; same-line reads blocked throughout FILL
    do_fill(4'd5, 1'b0, 32'h43424140, 3, 1, 1'b0, 32'h03020100);
    do_read(4'd5, 1'b0, 4'd0, 32'h43424140);
    do_read(4'd5, 1'b0, 4'd8, 32'h4B4A4948);

    // Reads to other lines during a fill, plus an ignored restart to set 2
    do_fill(4'd5, 1'b0, 32'h83828180, 0, 2, 1'b1, 32'h43424140);
    do_read(4'd2, 1'b0, 4'd0,  32'h0);
    do_read(4'd5, 1'b0, 4'd4,  32'h87868584);
    do_read(4'd5, 1'b0, 4'd12, 32'h8F8E8D8C);

    // Reset after two beats abandons the fill and clears the array
    fill_start = 1'b1; fill_set = 4'd7; fill_way = 1'b1;
    step();
    fill_start = 1'b0;
    for (int k = 0; k < 2; k++) begin
      beat_valid = 1'b1; beat_data = 32'hA5A5A5A5 + 32'(k);
      step();
    end
    beat_valid = 1'b0;
    chk("busy_pre_rst", 32'(fill_busy), 32'd1);
    rsn = 1'b0;
    #1;
    chk("busy_in_rst", 32'(fill_busy), 32'd0);
    chk("ready_in_rst", 32'(beat_ready), 32'd0);
    chk("data_in_rst", rd_data, 32'd0);
    step();
    rsn = 1'b1;
    step();
    chk("busy_after_rst", 32'(fill_busy), 32'd0);
    do_read(4'd7, 1'b1, 4'd0,  32'h0);
    do_read(4'd5, 1'b0, 4'd12, 32'h0);
    do_fill(4'd7, 1'b1, 32'hC3C2C1C0, 0, 0, 1'b0, 32'h0);
    do_read(4'd7, 1'b1, 4'd8, 32'hCBCAC9C8);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
